mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port-to-one memory arbiter and sequencer that lets the instruction-fetch path and the load/store path share a single unified, multi-cycle memory port. It sits between the program counter / instruction-fetch logic and the load/store datapath on the core side, and drives the memory array on the other side. It arbitrates round-robin when both sides request, launches one transaction at a time, and returns read data with a single-cycle valid pulse.

## Interface
- BITNESS, 32, address/data width
- LATENCY, 2, memory read latency in cycles, legal range 1..15

- clk_i  in  1  clock, rising-edge
- rst_i  in  1  asynchronous, active-high reset
- ifReq_i  in  1  fetch request, held until granted (may be withdrawn)
- ifAddr_i  in  BITNESS  fetch address
- ifGnt_o  out  1  fetch accepted this cycle (combinational)
- ifRvalid_o  out  1  fetch data valid, one-cycle pulse
- ifRdata_o  out  BITNESS  fetch data
- dReq_i  in  1  load/store request
- dWe_i  in  1  1 = store, 0 = load
- dAddr_i  in  BITNESS  data address
- dWdata_i  in  BITNESS  store data
- dCtrl_i  in  3  funct3 width/sign control, passed to memory
- dGnt_o  out  1  data request accepted this cycle (combinational)
- dRvalid_o  out  1  load data valid or store complete, one-cycle pulse
- dRdata_o  out  BITNESS  load data (0 for stores)
- memAddr_o  out  BITNESS  registered memory address
- memWe_o  out  1  registered write enable
- memWdata_o  out  BITNESS  registered write data
- memCtrl_o  out  3  registered funct3 control (010 for fetches)
- memRdata_i  in  BITNESS  memory read data
- busy_o  out  1  transaction in flight

## Operation
- States: IDLE, BUSY.
- IDLE: grant is combinational from requests. One request -> grant it. Both -> grant the port not granted last (lastGnt register). Reset value of lastGnt = fetch, so the first tie goes to data.
- Exactly one of ifGnt_o/dGnt_o can be high. Grants are only ever high in IDLE.
- On the rising edge where a grant is high (accept edge E0):
  - register memAddr_o, memWe_o, memWdata_o and memCtrl_o;
  - record the owner and update lastGnt;
  - load the counter with LATENCY for a load or fetch, or 1 for a store;
  - go to BUSY.
- Fetch accepts drive memWe_o=0 and memCtrl_o=010.
- BUSY: the counter decrements each edge.
  - On the edge where the counter reaches 0, capture memRdata_i into the owner's rdata register (0 for a store), pulse the owner's Rvalid_o for the following cycle, clear memWe_o and return to IDLE.
- memWe_o is high for exactly one cycle per store: the cycle after E0.
- memAddr_o and memCtrl_o hold their value until the next accept.
- A request that deasserts before it is granted is simply dropped. No state change.
- Requests arriving while BUSY wait. Grants stay low.
- busy_o = (state == BUSY).
- Counter width is 4 bits. LATENCY outside 1..15 is a parameter error (elaboration assertion).

## Timing
- Load/fetch response: rvalid is high in the cycle after edge E0+LATENCY.
  - Data is memRdata_i sampled at that edge. Memory must present data LATENCY cycles after memAddr_o changes.
- Store completion: dRvalid_o is high in the cycle after edge E0+1.
- Back-to-back: a new grant may be high in the same cycle as the previous rvalid pulse.
  - Read throughput is one per LATENCY+1 cycles.
  - Store throughput is one per 2 cycles.
- Simultaneous rvalid for one port and a grant for the other port in the same cycle is legal.
- rdata registers hold their value after the pulse until the next capture for that port.
- Reset (asynchronous, takes effect immediately, no clock needed):
  - state = IDLE, counter = 0, lastGnt = fetch;
  - all outputs 0, including memWe_o, both Rvalid_o and both rdata registers.
  - An in-flight transaction is discarded. No rvalid is produced after reset releases.
- Grants are low while rst_i is high.

## Test plan
- Single fetch, LATENCY=2: ifReq_i=1 and ifAddr_i=0x10 in cycle 0.
  - Required: ifGnt_o=1 in cycle 0; memAddr_o=0x10 from cycle 1; memCtrl_o=010.
  - Required: with memRdata_i=0xDEADBEEF, ifRvalid_o=1 in cycle 3 only, ifRdata_o=0xDEADBEEF.
- Store: dReq_i=1, dWe_i=1, dAddr_i=0x20, dWdata_i=0x55, dCtrl_i=000.
  - Required: memWe_o=1 in cycle 1 only; memWdata_o=0x55; dRvalid_o=1 in cycle 2; dRdata_o=0.
- Contention: both requests held continuously from reset.
  - Required: grant order data, fetch, data, fetch; no grant while busy_o=1.
- Back-to-back loads, LATENCY=3: dReq_i held high.
  - Required: dGnt_o pulses in cycles 0, 4 and 8; dRvalid_o pulses in cycles 4 and 8, each coinciding with the next grant.
- Reset mid-read: fetch accepted in cycle 0, rst_i=1 asynchronously in cycle 1 and released in cycle 2.
  - Required: busy_o and memAddr_o go to 0 immediately; no ifRvalid_o pulse is ever produced.
  - Required: the next tie after reset is granted to data.
- Withdrawn request: ifReq_i=1 for one cycle while busy, then 0.
  - Required: ifGnt_o never asserts; no fetch is issued; state returns to IDLE and stays there.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between fetch and load/store.
// Ports: if* fetch side, d* data side, mem* memory side, busy_o in-flight flag.
module mem_arbiter #(
  parameter int BITNESS = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ifReq_i,
  input  logic [BITNESS-1:0] ifAddr_i,
  output logic               ifGnt_o,
  output logic               ifRvalid_o,
  output logic [BITNESS-1:0] ifRdata_o,
  input  logic               dReq_i,
  input  logic               dWe_i,
  input  logic [BITNESS-1:0] dAddr_i,
  input  logic [BITNESS-1:0] dWdata_i,
  input  logic [2:0]         dCtrl_i,
  output logic               dGnt_o,
  output logic               dRvalid_o,
  output logic [BITNESS-1:0] dRdata_o,
  output logic [BITNESS-1:0] memAddr_o,
  output logic               memWe_o,
  output logic [BITNESS-1:0] memWdata_o,
  output logic [2:0]         memCtrl_o,
  input  logic [BITNESS-1:0] memRdata_i,
  output logic               busy_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: LATENCY must be in 1..15");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic               store_q, store_d;
  logic [BITNESS-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [BITNESS-1:0] wdata_q, wdata_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               if_rv_q, if_rv_d;
  logic               d_rv_q, d_rv_d;
  logic [BITNESS-1:0] if_rd_q, if_rd_d;
  logic [BITNESS-1:0] d_rd_q, d_rd_d;
  logic               if_gnt, d_gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    store_d = store_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    if_rd_d = if_rd_q;
    d_rd_d  = d_rd_q;
    if_rv_d = 1'b0;
    d_rv_d  = 1'b0;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie, the port that did not win last time wins now.
        if (!rst_i) begin
          if_gnt = ifReq_i & (~dReq_i | (last_q == OWN_D));
          d_gnt  = dReq_i & (~ifReq_i | (last_q == OWN_IF));
        end
        if (if_gnt) begin
          state_d = BUSY;
          cnt_d   = LAT4;
          last_d  = OWN_IF;
          owner_d = OWN_IF;
          store_d = 1'b0;
          addr_d  = ifAddr_i;
          we_d    = 1'b0;
          wdata_d = '0;
          ctrl_d  = 3'b010;
        end else if (d_gnt) begin
          state_d = BUSY;
          cnt_d   = dWe_i ? 4'd1 : LAT4;
          last_d  = OWN_D;
          owner_d = OWN_D;
          store_d = dWe_i;
          addr_d  = dAddr_i;
          we_d    = dWe_i;
          wdata_d = dWdata_i;
          ctrl_d  = dCtrl_i;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // Counter hits zero on this edge: finish the transaction.
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          we_d    = 1'b0;
          if (owner_q == OWN_IF) begin
            if_rv_d = 1'b1;
            if_rd_d = memRdata_i;
          end else begin
            d_rv_d = 1'b1;
            d_rd_d = store_q ? '0 : memRdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= OWN_IF;
      owner_q <= OWN_IF;
      store_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      if_rv_q <= 1'b0;
      d_rv_q  <= 1'b0;
      if_rd_q <= '0;
      d_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      if_rv_q <= if_rv_d;
      d_rv_q  <= d_rv_d;
      if_rd_q <= if_rd_d;
      d_rd_q  <= d_rd_d;
    end
  end

  assign ifGnt_o    = if_gnt;
  assign dGnt_o     = d_gnt;
  assign ifRvalid_o = if_rv_q;
  assign dRvalid_o  = d_rv_q;
  assign ifRdata_o  = if_rd_q;
  assign dRdata_o   = d_rd_q;
  assign memAddr_o  = addr_q;
  assign memWe_o    = we_q;
  assign memWdata_o = wdata_q;
  assign memCtrl_o  = ctrl_q;
  assign busy_o     = (state_q == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with rdata scoreboard for mem_arbiter.
// Instance a uses LATENCY=2, instance b uses LATENCY=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [2:0]  d_ctrl = 0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;

  logic        b_d_req = 0;
  logic [31:0] b_d_addr = 0;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [2:0]  b_mem_ctrl;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata   = mem_f(mem_addr);
  assign b_mem_rdata = mem_f(b_mem_addr);

  mem_arbiter #(.BITNESS(32), .LATENCY(2)) u_a (
    .clk_i(clk), .rst_i(rst),
    .ifReq_i(if_req), .ifAddr_i(if_addr), .ifGnt_o(if_gnt),
    .ifRvalid_o(if_rvalid), .ifRdata_o(if_rdata),
    .dReq_i(d_req), .dWe_i(d_we), .dAddr_i(d_addr),
    .dWdata_i(d_wdata), .dCtrl_i(d_ctrl), .dGnt_o(d_gnt),
    .dRvalid_o(d_rvalid), .dRdata_o(d_rdata),
    .memAddr_o(mem_addr), .memWe_o(mem_we), .memWdata_o(mem_wdata),
    .memCtrl_o(mem_ctrl), .memRdata_i(mem_rdata), .busy_o(busy)
  );

  mem_arbiter #(.BITNESS(32), .LATENCY(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .ifReq_i(1'b0), .ifAddr_i(32'h0), .ifGnt_o(b_if_gnt),
    .ifRvalid_o(b_if_rvalid), .ifRdata_o(b_if_rdata),
    .dReq_i(b_d_req), .dWe_i(1'b0), .dAddr_i(b_d_addr),
    .dWdata_i(32'h0), .dCtrl_i(3'b010), .dGnt_o(b_d_gnt),
    .dRvalid_o(b_d_rvalid), .dRdata_o(b_d_rdata),
    .memAddr_o(b_mem_addr), .memWe_o(b_mem_we), .memWdata_o(b_mem_wdata),
    .memCtrl_o(b_mem_ctrl), .memRdata_i(b_mem_rdata), .busy_o(b_busy)
  );

  int tests = 0;
  int fails = 0;
  int if_rv_cnt = 0;
  int b_cyc = 0;
  logic [31:0] ifq[$], dq[$], bq[$];
  logic gnt_log[$];
  int b_gnt_cyc[$], b_rv_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    chk("gnt_onehot", 32'(if_gnt & d_gnt), 0);
    if (busy) chk("gnt_while_busy", {30'd0, if_gnt, d_gnt}, 0);
    if (b_busy) chk("b_gnt_while_busy", 32'(b_d_gnt), 0);
    if (if_rvalid) begin
      if_rv_cnt++;
      chk("if_rv_expected", 32'(ifq.size() != 0), 1);
      if (ifq.size() != 0) chk("if_rdata", if_rdata, ifq.pop_front());
    end
    if (d_rvalid) begin
      chk("d_rv_expected", 32'(dq.size() != 0), 1);
      if (dq.size() != 0) chk("d_rdata", d_rdata, dq.pop_front());
    end
    if (b_d_rvalid) begin
      b_rv_cyc.push_back(b_cyc);
      chk("b_rv_expected", 32'(bq.size() != 0), 1);
      if (bq.size() != 0) chk("b_rdata", b_d_rdata, bq.pop_front());
    end
    if (if_gnt) begin
      ifq.push_back(mem_f(if_addr));
      gnt_log.push_back(1'b0);
    end
    if (d_gnt) begin
      dq.push_back(d_we ? 32'h0 : mem_f(d_addr));
      gnt_log.push_back(1'b1);
    end
    if (b_d_gnt) begin
      b_gnt_cyc.push_back(b_cyc);
      bq.push_back(mem_f(b_d_addr));
    end
    b_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      samp();
      nxt();
    end
  endtask

  int rv0;

  initial begin
    if_req = 1; d_req = 1;
    #7;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_ctrl", 32'(mem_ctrl), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    nxt();
    rst = 0; if_req = 0; d_req = 0;

    // single fetch
    if_req = 1; if_addr = 32'h10;
    samp();
    chk("f_if_gnt", 32'(if_gnt), 1);
    chk("f_d_gnt", 32'(d_gnt), 0);
    nxt();
    if_req = 0;
    samp();
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_ctrl", 32'(mem_ctrl), 32'h2);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_busy", 32'(busy), 1);
    chk("f_rv_c1", 32'(if_rvalid), 0);
    nxt();
    samp();
    chk("f_rv_c2", 32'(if_rvalid), 0);
    nxt();
    samp();
    chk("f_rv_c3", 32'(if_rvalid), 1);
    chk("f_rdata", if_rdata, 32'hDEADBEEF);
    nxt();
    samp();
    chk("f_rv_c4", 32'(if_rvalid), 0);
    chk("f_idle", 32'(busy), 0);
    chk("f_rdata_hold", if_rdata, 32'hDEADBEEF);
    nxt();

    // load then store
    d_req = 1; d_we = 0; d_addr = 32'h30; d_ctrl = 3'b010;
    samp();
    chk("ld_gnt", 32'(d_gnt), 1);
    nxt();
    d_req = 0;
    idle(4);
    chk("ld_rdata_hold", d_rdata, 32'h0030FFCF);
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; d_ctrl = 3'b000;
    samp();
    chk("st_gnt", 32'(d_gnt), 1);
    chk("st_we_c0", 32'(mem_we), 0);
    nxt();
    d_req = 0; d_we = 0;
    samp();
    chk("st_we_c1", 32'(mem_we), 1);
    chk("st_wdata", mem_wdata, 32'h55);
    chk("st_addr", mem_addr, 32'h20);
    chk("st_ctrl", 32'(mem_ctrl), 0);
    chk("st_rv_c1", 32'(d_rvalid), 0);
    nxt();
    samp();
    chk("st_we_c2", 32'(mem_we), 0);
    chk("st_rv_c2", 32'(d_rvalid), 1);
    chk("st_rdata", d_rdata, 0);
    nxt();
    samp();
    chk("st_rv_c3", 32'(d_rvalid), 0);
    chk("st_idle", 32'(busy), 0);
    nxt();

    // withdrawn fetch request while busy
    gnt_log.delete();
    rv0 = if_rv_cnt;
    d_req = 1; d_addr = 32'h40;
    samp();
    chk("wd_d_gnt", 32'(d_gnt), 1);
    nxt();
    d_req = 0; if_req = 1; if_addr = 32'h44;
    samp();
    chk("wd_if_gnt_busy", 32'(if_gnt), 0);
    nxt();
    if_req = 0;
    samp();
    chk("wd_if_gnt_after", 32'(if_gnt), 0);
    nxt();
    samp();
    chk("wd_d_rv", 32'(d_rvalid), 1);
    nxt();
    idle(4);
    chk("wd_idle", 32'(busy), 0);
    chk("wd_mem_addr", mem_addr, 32'h40);
    chk("wd_gnt_count", gnt_log.size(), 1);
    chk("wd_if_rv", if_rv_cnt - rv0, 0);

    // reset during an in-flight fetch
    if_req = 1; if_addr = 32'h50;
    samp();
    chk("rm_gnt", 32'(if_gnt), 1);
    nxt();
    if_req = 0;
    #2 rst = 1;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_mem_addr", mem_addr, 0);
    samp();
    ifq.delete();
    nxt();
    rst = 0;
    rv0 = if_rv_cnt;
    idle(5);
    chk("rm_no_if_rv", if_rv_cnt - rv0, 0);

    // contention right after reset
    gnt_log.delete();
    if_req = 1; if_addr = 32'h60;
    d_req = 1; d_we = 0; d_addr = 32'h70;
    for (int i = 0; i < 20 && gnt_log.size() < 4; i++) begin
      samp();
      nxt();
    end
    if_req = 0; d_req = 0;
    chk("ct_gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() >= 4) begin
      chk("ct_order0", 32'(gnt_log[0]), 1);
      chk("ct_order1", 32'(gnt_log[1]), 0);
      chk("ct_order2", 32'(gnt_log[2]), 1);
      chk("ct_order3", 32'(gnt_log[3]), 0);
    end
    idle(5);
    chk("ct_ifq_empty", ifq.size(), 0);
    chk("ct_dq_empty", dq.size(), 0);

    // back-to-back loads, LATENCY=3
    b_cyc = 0;
    b_gnt_cyc.delete();
    b_rv_cyc.delete();
    b_d_req = 1; b_d_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      samp();
      nxt();
      if (b_gnt_cyc.size() != 0) b_d_addr = 32'h80 + 32'(4 * b_gnt_cyc.size());
    end
    b_d_req = 0;
    chk("bb_gnt_count", b_gnt_cyc.size(), 3);
    chk("bb_rv_count", b_rv_cyc.size(), 2);
    if (b_gnt_cyc.size() == 3) begin
      chk("bb_gnt0", b_gnt_cyc[0], 0);
      chk("bb_gnt1", b_gnt_cyc[1], 4);
      chk("bb_gnt2", b_gnt_cyc[2], 8);
    end
    if (b_rv_cyc.size() == 2) begin
      chk("bb_rv0", b_rv_cyc[0], 4);
      chk("bb_rv1", b_rv_cyc[1], 8);
    end
    idle(5);
    chk("bb_q_empty", bq.size(), 0);
    chk("bb_idle", 32'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
